// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writebacks take priority over a small FIFO
// of late (out-of-order) results. It also provides a starvation freeze request and a pending-write lookup.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     late_valid,
    output logic                     late_ready,
    input  logic [4:0]               late_reg,
    input  logic [31:0]              late_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [31:0]              rf_wdata,
    output logic                     freeze_req,
    input  logic [4:0]               busy_query_reg,
    output logic                     busy_hit,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0] CNT_ONE = 1;

    logic          live_q [DEPTH];
    logic [4:0]    reg_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;

    logic head_live, head_dead, wb_ok, late_acc;
    logic take_wb, take_head, pop, blocked, starve_hit, enq_live;

    // Late handshake: a result transfers on a cycle where late_valid && late_ready;
    // late_ready depends only on occupancy, never on late_valid.
    always_comb begin
        head_live  = (count != '0) && live_q[rd_ptr];
        head_dead  = (count != '0) && !live_q[rd_ptr];
        wb_ok      = wb_valid && (wb_reg != 5'd0);
        late_ready = (count < (AW+1)'(DEPTH));
        late_acc   = late_valid && late_ready;
        take_wb    = 1'b0;
        take_head  = 1'b0;
        // A dead head is discarded without using the port, so the pipeline may still write.
        if (head_dead) begin
            take_wb = wb_ok && !freeze_req;
        end else if (freeze_req) begin
            take_head = head_live;
        end else if (wb_ok) begin
            take_wb = 1'b1;
        end else begin
            take_head = head_live;
        end
        pop        = head_dead || take_head;
        blocked    = head_live && !take_head;
        starve_hit = blocked && (starve_cnt == SW'(STARVE_LIMIT - 1));
        // The pipeline write is younger in program order, so a same-cycle late result to that reg is stale.
        enq_live   = (late_reg != 5'd0) && !(take_wb && (late_reg == wb_reg));
    end

    always_comb begin
        busy_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (reg_q[i] == busy_query_reg)) busy_hit = 1'b1;
        end
    end

    assign fifo_count = count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            freeze_req <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            if (take_wb) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (reg_q[i] == wb_reg) live_q[i] <= 1'b0;
                end
            end
            // Freed slots are marked dead so busy_hit needs no occupancy check.
            if (pop) begin
                live_q[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (late_acc) begin
                live_q[wr_ptr] <= enq_live;
                reg_q[wr_ptr]  <= late_reg;
                data_q[wr_ptr] <= late_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (late_acc && !pop) count <= count + CNT_ONE;
            else if (!late_acc && pop) count <= count - CNT_ONE;

            if (!blocked) starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            freeze_req <= starve_hit;

            rf_we <= take_wb || take_head;
            if (take_wb) begin
                rf_waddr <= wb_reg;
                rf_wdata <= wb_data;
            end else if (take_head) begin
                rf_waddr <= reg_q[rd_ptr];
                rf_wdata <= data_q[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with a mid-run reset.
module tb_wb_port_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        CLK;
    logic        RESET;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_reg;
    logic [31:0] late_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        freeze_req;
    logic [4:0]  busy_query_reg;
    logic        busy_hit;
    logic [2:0]  fifo_count;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .late_valid(late_valid), .late_ready(late_ready),
        .late_reg(late_reg), .late_data(late_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .freeze_req(freeze_req),
        .busy_query_reg(busy_query_reg), .busy_hit(busy_hit),
        .fifo_count(fifo_count)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: queue of pending late results
    typedef struct {
        logic        live;
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we, m_freeze;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_blocked_run;
    bit          s_acc, s_wb_ok, s_wr_wb, s_pop_live, s_head_live;
    ent_t        s_e;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mq.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_freeze = 0; m_blocked_run = 0;
        end else begin
            s_acc       = late_valid && (mq.size() < DEPTH);
            s_wb_ok     = wb_valid && (wb_reg != 0);
            s_head_live = (mq.size() > 0) && mq[0].live;
            s_wr_wb     = 0;
            s_pop_live  = 0;
            if (mq.size() > 0 && !mq[0].live) begin
                void'(mq.pop_front());
                s_wr_wb = s_wb_ok && !m_freeze;
            end else if (m_freeze) begin
                if (mq.size() > 0) begin s_e = mq.pop_front(); s_pop_live = 1; end
            end else if (s_wb_ok) begin
                s_wr_wb = 1;
            end else if (mq.size() > 0) begin
                s_e = mq.pop_front(); s_pop_live = 1;
            end
            m_we = s_wr_wb || s_pop_live;
            if (s_wr_wb) begin
                m_addr = wb_reg; m_data = wb_data;
                foreach (mq[i]) if (mq[i].r == wb_reg) mq[i].live = 0;
            end else if (s_pop_live) begin
                m_addr = s_e.r; m_data = s_e.d;
            end
            if (s_head_live && !s_pop_live) m_blocked_run++;
            else m_blocked_run = 0;
            m_freeze = (m_blocked_run == STARVE_LIMIT);
            if (s_acc)
                mq.push_back('{live: (late_reg != 0) && !(s_wr_wb && wb_reg == late_reg),
                               r: late_reg, d: late_data});
        end
    end

    function automatic bit model_busy(input logic [4:0] q);
        foreach (mq[i]) if (mq[i].live && mq[i].r == q) return 1;
        return 0;
    endfunction

    // every-cycle compare against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("rf_we", rf_we, m_we);
            if (m_we) begin
                chk("rf_waddr", rf_waddr, m_addr);
                chk("rf_wdata", rf_wdata, m_data);
            end
            chk("freeze_req", freeze_req, m_freeze);
            chk("fifo_count", fifo_count, mq.size());
            chk("late_ready", late_ready, mq.size() < DEPTH);
            chk("busy_hit", busy_hit, model_busy(busy_query_reg));
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic mid();
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        late_valid = 0; late_reg = 0; late_data = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rf_we"}, rf_we, 0);
        chk({tag, "_rf_waddr"}, rf_waddr, 0);
        chk({tag, "_rf_wdata"}, rf_wdata, 0);
        chk({tag, "_freeze"}, freeze_req, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_late_ready"}, late_ready, 1);
        chk({tag, "_busy_hit"}, busy_hit, 0);
    endtask

    bit got;

    initial begin
        RESET = 0;
        busy_query_reg = 0;
        idle();
        repeat (3) cyc();
        late_valid = 1; late_reg = 5'd4; busy_query_reg = 5'd4;
        mid();
        check_reset_vals("reset");
        cyc();
        RESET = 1;
        idle();
        chk_en = 1;

        // pipeline write, then dropped write to r0
        cyc(); wb_valid = 1; wb_reg = 5'd5; wb_data = 32'h0000_1234;
        cyc(); wb_valid = 1; wb_reg = 5'd0; wb_data = 32'hFFFF_FFFF;
        mid();
        chk("wb_we", rf_we, 1);
        chk("wb_addr", rf_waddr, 5);
        chk("wb_data", rf_wdata, 32'h1234);
        cyc(); idle();
        mid();
        chk("wb_r0_we", rf_we, 0);

        // late write on idle port
        cyc(); late_valid = 1; late_reg = 5'd7; late_data = 32'hDEAD_BEEF;
        mid();
        chk("late_ready_idle", late_ready, 1);
        cyc(); idle();
        mid();
        chk("late_cnt_n1", fifo_count, 1);
        chk("late_we_n1", rf_we, 0);
        cyc();
        mid();
        chk("late_we_n2", rf_we, 1);
        chk("late_addr_n2", rf_waddr, 7);
        chk("late_data_n2", rf_wdata, 32'hDEAD_BEEF);
        chk("late_cnt_n2", fifo_count, 0);

        // kill of a queued entry
        cyc(); late_valid = 1; late_reg = 5'd9; late_data = 32'h99; wb_valid = 1; wb_reg = 5'd20; wb_data = 32'h20;
        cyc(); late_valid = 0; wb_reg = 5'd9; wb_data = 32'h11; busy_query_reg = 5'd9;
        mid();
        chk("kill_busy_before", busy_hit, 1);
        cyc(); idle();
        mid();
        chk("kill_busy_after", busy_hit, 0);
        chk("kill_we", rf_we, 1);
        chk("kill_addr", rf_waddr, 9);
        chk("kill_data", rf_wdata, 32'h11);
        chk("kill_cnt", fifo_count, 1);
        cyc();
        mid();
        chk("kill_dead_pop_we", rf_we, 0);
        chk("kill_dead_pop_cnt", fifo_count, 0);

        // same-cycle kill
        cyc(); late_valid = 1; late_reg = 5'd12; late_data = 32'hBAD; wb_valid = 1; wb_reg = 5'd12; wb_data = 32'h12;
        busy_query_reg = 5'd12;
        cyc(); idle();
        mid();
        chk("same_we", rf_we, 1);
        chk("same_addr", rf_waddr, 12);
        chk("same_data", rf_wdata, 32'h12);
        chk("same_busy", busy_hit, 0);
        cyc();
        mid();
        chk("same_dead_we", rf_we, 0);
        chk("same_dead_cnt", fifo_count, 0);

        // starvation
        cyc(); late_valid = 1; late_reg = 5'd3; late_data = 32'hA5A5_A5A5; wb_valid = 1; wb_reg = 5'd1; wb_data = 32'h1;
        for (int k = 1; k <= 8; k++) begin
            cyc(); late_valid = 0; wb_reg = 5'(1 + k % 2); wb_data = k;
            mid();
            chk("starve_no_freeze", freeze_req, 0);
        end
        cyc(); wb_reg = 5'd4; wb_data = 32'h44;
        mid();
        chk("starve_freeze", freeze_req, 1);
        cyc(); wb_reg = 5'd5; wb_data = 32'h55;
        mid();
        chk("starve_freeze_drop", freeze_req, 0);
        chk("starve_we", rf_we, 1);
        chk("starve_addr", rf_waddr, 3);
        chk("starve_data", rf_wdata, 32'hA5A5_A5A5);
        cyc(); idle();
        mid();
        chk("starve_next_addr", rf_waddr, 5);
        chk("starve_next_data", rf_wdata, 32'h55);

        // full FIFO
        for (int i = 0; i < 5; i++) begin
            cyc(); wb_valid = 1; wb_reg = 5'(1 + i % 2); wb_data = 32'h100 + i;
            late_valid = 1; late_reg = 5'(21 + i); late_data = 32'hC000 + i;
        end
        mid();
        chk("full_cnt", fifo_count, 4);
        chk("full_ready", late_ready, 0);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cyc(); wb_reg = 5'(1 + k % 2); wb_data = 32'h200 + k;
            mid();
            if (late_ready) got = 1;
        end
        chk("full_release", got, 1);
        if (got) chk("full_cnt_at_release", fifo_count, 3);
        cyc(); idle();
        repeat (8) cyc();

        // randomized traffic with one mid-run reset
        for (int n = 0; n < 1500; n++) begin
            cyc();
            if (n == 700) begin
                RESET = 0;
                mid();
                check_reset_vals("midreset");
                cyc();
                RESET = 1;
            end
            wb_valid       = ($urandom_range(0, 99) < 55);
            wb_reg         = 5'($urandom_range(0, 7));
            wb_data        = $urandom();
            late_valid     = ($urandom_range(0, 99) < 45);
            late_reg       = 5'($urandom_range(0, 7));
            late_data      = $urandom();
            busy_query_reg = 5'($urandom_range(0, 7));
        end
        cyc(); idle();
        repeat (12) cyc();
        mid();
        chk("drain_cnt", fifo_count, 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
